mem_test_engine: RTL and testbench

//  Parametrised memory exerciser. Generates write/read transactions against a memory

---
 rtl/mem_test_pkg.sv | 28 ++
 rtl/mem_test_pattern.sv | 46 ++++
 rtl/mem_test_engine.sv | 260 ++++++++++++++++++++++++++
 tb/tb_mem_test_engine.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_test_pkg.sv
// Shared encodings for the memory test engine.
//   - run modes and pattern selectors as they appear on the mode / pat_sel ports
//   - FSM state encoding
//   - golden-ratio multiplier used by the hash pattern
package mem_test_pkg;

    localparam logic [1:0] MODE_INTERLEAVE = 2'd0;  // W/R per word
    localparam logic [1:0] MODE_SWEEP      = 2'd1;  // all writes, then all reads
    localparam logic [1:0] MODE_VERIFY     = 2'd2;  // read-only check of existing contents
    localparam logic [1:0] MODE_LOOP       = 2'd3;  // interleaved, repeated until stop

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_NADDR = 2'd1;
    localparam logic [1:0] PAT_HASH  = 2'd2;
    localparam logic [1:0] PAT_WALK1 = 2'd3;

    localparam logic [31:0] GOLDEN = 32'h9E37_79B1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WGAP = 3'd2,
        ST_RD   = 3'd3,
        ST_RGAP = 3'd4,
        ST_FIN  = 3'd5
    } state_e;

endpackage

// File: rtl/mem_test_pattern.sv
// Combinational test-pattern generator shared by the write and check paths.
// Ports:
//   idx_i      word index within the pass
//   addr_i     transaction address for this word
//   pat_sel_i  pattern selector (see mem_test_pkg PAT_*)
//   data_o     expected/written data word
module mem_test_pattern
    import mem_test_pkg::*;
#(
    parameter int          AW   = 32,
    parameter int          DW   = 32,
    parameter int          CW   = 16,
    parameter logic [31:0] SEED = 32'h1234_5678
) (
    input  logic [CW-1:0] idx_i,
    input  logic [AW-1:0] addr_i,
    input  logic [1:0]    pat_sel_i,
    output logic [DW-1:0] data_o
);

    localparam logic [DW-1:0] ONE_DW = {{(DW-1){1'b0}}, 1'b1};

    logic [DW-1:0] addr_s;
    logic [DW-1:0] hash_s;
    logic [DW-1:0] walk_s;
    logic [CW-1:0] shift_s;

    // Every pattern is taken modulo 2^DW; the address patterns use its low DW bits.
    assign addr_s  = DW'(addr_i);
    assign hash_s  = DW'(idx_i) * DW'(GOLDEN) + DW'(SEED);
    assign shift_s = idx_i % CW'(DW);
    assign walk_s  = ONE_DW << shift_s;

    // Pattern select.
    always_comb begin
        data_o = addr_s;
        case (pat_sel_i)
            PAT_ADDR:  data_o = addr_s;
            PAT_NADDR: data_o = ~addr_s;
            PAT_HASH:  data_o = hash_s;
            PAT_WALK1: data_o = walk_s;
            default:   data_o = addr_s;
        endcase
    end

endmodule

// File: rtl/mem_test_engine.sv
// Memory exerciser: drives write/read transactions over a we/rd/ack port and
// checks the read-back data against a regenerated pattern.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, stop              run launch pulse, abort request (level)
//   mode, pat_sel            run mode and data pattern, latched on start
//   base_addr, word_count    first address and words per pass, latched on start
//   mem_*                    device port (request held until ack)
//   busy, done, pass         run status; done pulses once per run
//   err_count, first_err_*   mismatch count and first failing address/data
//   last_rd_data             most recent read data
//   loop_count               completed passes in loop mode
module mem_test_engine
    import mem_test_pkg::*;
#(
    parameter int          AW        = 32,
    parameter int          DW        = 32,
    parameter int          CW        = 16,
    parameter int          ADDR_STEP = 1,
    parameter logic [31:0] SEED      = 32'h1234_5678
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [1:0]    pat_sel,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] word_count,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_o,
    input  logic [DW-1:0] mem_data_i,
    output logic          mem_we_o,
    output logic          mem_rd_o,
    input  logic          mem_ack_i,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] err_count,
    output logic [AW-1:0] first_err_addr,
    output logic [DW-1:0] first_err_data,
    output logic [DW-1:0] last_rd_data,
    output logic [CW-1:0] loop_count
);

    localparam logic [CW-1:0] ZERO_CW = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CW  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ALL1_CW = {CW{1'b1}};

    state_e        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [1:0]    pat_q, pat_d;
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] err_q, err_d;
    logic          pass_q, pass_d;
    logic [AW-1:0] ferr_addr_q, ferr_addr_d;
    logic [DW-1:0] ferr_data_q, ferr_data_d;
    logic [DW-1:0] last_rd_q, last_rd_d;
    logic [CW-1:0] loop_q, loop_d;

    logic [AW-1:0] addr_s;
    logic [DW-1:0] pat_s;
    logic          last_s;
    logic          we_s, rd_s, busy_s, done_s;

    // Address wraps modulo 2^AW by construction.
    assign addr_s = base_q + AW'(idx_q) * AW'(ADDR_STEP);
    // count_q is never zero outside IDLE/FIN, so the decrement cannot underflow where used.
    assign last_s = (idx_q == (count_q - ONE_CW));

    mem_test_pattern #(
        .AW   (AW),
        .DW   (DW),
        .CW   (CW),
        .SEED (SEED)
    ) u_pattern (
        .idx_i     (idx_q),
        .addr_i    (addr_s),
        .pat_sel_i (pat_q),
        .data_o    (pat_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; stop is only looked at between transactions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!start)                        state_d = ST_IDLE;
                else if (word_count == ZERO_CW)    state_d = ST_FIN;
                else if (mode == MODE_VERIFY)      state_d = ST_RD;
                else                               state_d = ST_WR;
            end
            ST_WR: begin
                if (mem_ack_i) state_d = ST_WGAP;
                else           state_d = ST_WR;
            end
            ST_WGAP: begin
                if (stop)                                 state_d = ST_FIN;
                else if ((mode_q == MODE_SWEEP) && !last_s) state_d = ST_WR;
                else                                      state_d = ST_RD;
            end
            ST_RD: begin
                if (mem_ack_i) state_d = ST_RGAP;
                else           state_d = ST_RD;
            end
            ST_RGAP: begin
                if (stop)                          state_d = ST_FIN;
                else if (last_s)                   state_d = (mode_q == MODE_LOOP) ? ST_WR : ST_FIN;
                else if ((mode_q == MODE_INTERLEAVE) || (mode_q == MODE_LOOP))
                                                   state_d = ST_WR;
                else                               state_d = ST_RD;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        we_s   = 1'b0;
        rd_s   = 1'b0;
        done_s = 1'b0;
        case (state_q)
            ST_WR:   we_s   = 1'b1;
            ST_RD:   rd_s   = 1'b1;
            ST_FIN:  done_s = 1'b1;
            default: done_s = 1'b0;
        endcase
        busy_s = (state_q != ST_IDLE);
    end

    // Datapath next-state: run parameters, index, checker and status.
    always_comb begin
        mode_d      = mode_q;
        pat_d       = pat_q;
        base_d      = base_q;
        count_d     = count_q;
        idx_d       = idx_q;
        err_d       = err_q;
        pass_d      = pass_q;
        ferr_addr_d = ferr_addr_q;
        ferr_data_d = ferr_data_q;
        last_rd_d   = last_rd_q;
        loop_d      = loop_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    pat_d       = pat_sel;
                    base_d      = base_addr;
                    count_d     = word_count;
                    idx_d       = ZERO_CW;
                    err_d       = ZERO_CW;
                    pass_d      = 1'b0;
                    ferr_addr_d = {AW{1'b0}};
                    ferr_data_d = {DW{1'b0}};
                    loop_d      = ZERO_CW;
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_RD: begin
                if (mem_ack_i) begin
                    last_rd_d = mem_data_i;
                    if (mem_data_i != pat_s) begin
                        err_d = (err_q == ALL1_CW) ? err_q : (err_q + ONE_CW);
                        if (err_q == ZERO_CW) begin
                            ferr_addr_d = addr_s;
                            ferr_data_d = mem_data_i;
                        end else begin
                            ferr_addr_d = ferr_addr_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    last_rd_d = last_rd_q;
                end
            end
            ST_WGAP: begin
                // Only sweep mode advances after a write; the other modes read the same word next.
                if (!stop && (mode_q == MODE_SWEEP)) idx_d = last_s ? ZERO_CW : (idx_q + ONE_CW);
                else                                 idx_d = idx_q;
            end
            ST_RGAP: begin
                if (stop) begin
                    idx_d = idx_q;
                end else if (last_s) begin
                    if (mode_q == MODE_LOOP) begin
                        idx_d  = ZERO_CW;
                        loop_d = loop_q + ONE_CW;
                    end else begin
                        idx_d = idx_q;
                    end
                end else begin
                    idx_d = idx_q + ONE_CW;
                end
            end
            default: idx_d = idx_q;
        endcase
        // pass is settled on entry to FIN so it is already valid while done pulses.
        if ((state_d == ST_FIN) && (state_q != ST_FIN)) pass_d = (err_d == ZERO_CW);
        else                                            pass_d = pass_d;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= 2'd0;
            pat_q       <= 2'd0;
            base_q      <= {AW{1'b0}};
            count_q     <= ZERO_CW;
            idx_q       <= ZERO_CW;
            err_q       <= ZERO_CW;
            pass_q      <= 1'b0;
            ferr_addr_q <= {AW{1'b0}};
            ferr_data_q <= {DW{1'b0}};
            last_rd_q   <= {DW{1'b0}};
            loop_q      <= ZERO_CW;
        end else begin
            mode_q      <= mode_d;
            pat_q       <= pat_d;
            base_q      <= base_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            pass_q      <= pass_d;
            ferr_addr_q <= ferr_addr_d;
            ferr_data_q <= ferr_data_d;
            last_rd_q   <= last_rd_d;
            loop_q      <= loop_d;
        end
    end

    // Address and data are forced to zero whenever no request is outstanding.
    assign mem_we_o       = we_s;
    assign mem_rd_o       = rd_s;
    assign mem_addr_o     = (we_s || rd_s) ? addr_s : {AW{1'b0}};
    assign mem_data_o     = we_s ? pat_s : {DW{1'b0}};
    assign busy           = busy_s;
    assign done           = done_s;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = ferr_addr_q;
    assign first_err_data = ferr_data_q;
    assign last_rd_data   = last_rd_q;
    assign loop_count     = loop_q;

endmodule

// File: tb/tb_mem_test_engine.sv
module tb_mem_test_engine;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          start      = 1'b0;
    logic          stop       = 1'b0;
    logic [1:0]    mode       = 2'd0;
    logic [1:0]    pat_sel    = 2'd0;
    logic [AW-1:0] base_addr  = '0;
    logic [CW-1:0] word_count = '0;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] mem_data_i = '0;
    logic          mem_we_o, mem_rd_o;
    logic          mem_ack_i  = 1'b0;
    logic          busy, done, pass;
    logic [CW-1:0] err_count, loop_count;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_data, last_rd_data;

    always #5 clk = ~clk;

    mem_test_engine #(.AW(AW), .DW(DW), .CW(CW), .ADDR_STEP(1), .SEED(32'h1234_5678)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .pat_sel(pat_sel),
        .base_addr(base_addr), .word_count(word_count),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .mem_we_o(mem_we_o), .mem_rd_o(mem_rd_o), .mem_ack_i(mem_ack_i),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .last_rd_data(last_rd_data), .loop_count(loop_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  pat;
        logic [31:0] base;
        int          count;
        int          corrupt;
        logic [15:0] exp_err;
        bit          exp_pass;
        logic [31:0] exp_faddr;
        logic [31:0] exp_fdata;
        logic [31:0] exp_last;
    } vec_t;

    txn_t        log_q[$];
    logic [31:0] mem [logic [31:0]];
    int          lat       = 0;
    int          fixed_lat = -1;
    bit          prev_ack  = 1'b0;
    bit          prev_req  = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    int          proto_err = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick_lat();
        return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Reference pattern straight from the pattern definitions.
    function automatic logic [31:0] model_pat(input int unsigned idx, input logic [31:0] a, input logic [1:0] sel);
        case (sel)
            2'd0:    return a;
            2'd1:    return ~a;
            2'd2:    return idx * 32'h9E37_79B1 + 32'h1234_5678;
            default: return 32'h1 << (idx % 32);
        endcase
    endfunction

    // Memory device with random ack latency, plus handshake protocol watch.
    always @(negedge clk) begin
        if (rst) begin
            mem_ack_i = 1'b0;
            prev_ack  = 1'b0;
            prev_req  = 1'b0;
            lat       = pick_lat();
        end else begin
            if (mem_we_o && mem_rd_o) proto_err++;
            if (prev_ack && (mem_we_o || mem_rd_o)) proto_err++;
            if (prev_req && !prev_ack && !(mem_we_o || mem_rd_o)) proto_err++;
            if (prev_req && !prev_ack && (mem_addr_o != prev_addr || mem_data_o != prev_wdata)) proto_err++;
            prev_req   = mem_we_o || mem_rd_o;
            prev_addr  = mem_addr_o;
            prev_wdata = mem_data_o;
            if ((mem_we_o || mem_rd_o) && !mem_ack_i) begin
                if (lat == 0) begin
                    txn_t t;
                    mem_ack_i = 1'b1;
                    t.we   = mem_we_o;
                    t.addr = mem_addr_o;
                    if (mem_we_o) begin
                        mem[mem_addr_o] = mem_data_o;
                        t.data = mem_data_o;
                    end else begin
                        mem_data_i = mem_rd(mem_addr_o);
                        t.data = mem_data_i;
                    end
                    log_q.push_back(t);
                    lat = pick_lat();
                end else begin
                    lat--;
                end
            end else begin
                mem_ack_i = 1'b0;
            end
            prev_ack = mem_ack_i;
        end
    end

    task automatic launch(input logic [1:0] m, input logic [1:0] p, input logic [31:0] b, input int n);
        log_q.delete();
        @(negedge clk);
        mode = m; pat_sel = p; base_addr = b; word_count = 16'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("done_seen", seen, 1'b1);
        if (seen) begin
            @(negedge clk);
            check("done_one_cycle", done, 1'b0);
            check("idle_after_done", busy, 1'b0);
        end
    endtask

    // Builds the expected transaction list and status for a finished run and compares.
    task automatic check_run(input logic [1:0] m, input logic [1:0] p, input logic [31:0] b, input int n);
        txn_t exp_q[$];
        txn_t t;
        int e = 0;
        logic [31:0] fa = '0, fd = '0, lr = '0, a, pv;
        for (int i = 0; i < n; i++) begin
            a = b + 32'(i);
            if (m != 2'd2) begin
                t.we = 1'b1; t.addr = a; t.data = model_pat(i, a, p); exp_q.push_back(t);
                if (m == 2'd0) begin t.we = 1'b0; exp_q.push_back(t); lr = t.data; end
            end
        end
        for (int i = 0; i < n; i++) begin
            if (m != 2'd0) begin
                a  = b + 32'(i);
                pv = model_pat(i, a, p);
                t.we = 1'b0; t.addr = a; t.data = (m == 2'd2) ? mem_rd(a) : pv;
                exp_q.push_back(t);
                lr = t.data;
                if (t.data != pv) begin
                    if (e == 0) begin fa = a; fd = t.data; end
                    e++;
                end
            end
        end
        check("txn_count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("txn[%0d]", i), {31'd0, log_q[i].we, log_q[i].addr, log_q[i].data},
                  {31'd0, exp_q[i].we, exp_q[i].addr, exp_q[i].data});
        check("err_count", err_count, 16'(e));
        check("pass", pass, (e == 0));
        check("first_err_addr", first_err_addr, fa);
        check("first_err_data", first_err_data, fd);
        check("last_rd_data", last_rd_data, lr);
        check("loop_count", loop_count, 16'd0);
    endtask

    vec_t vecs[6];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  m, p;
        logic [31:0] b, a, v;
        int          n;
        bit          ok, found;

        vecs[0] = '{2'd0, 2'd0, 32'h0000_0100,  4, -1, 16'd0, 1'b1, 32'h0, 32'h0,         32'h0000_0103};
        vecs[1] = '{2'd1, 2'd3, 32'h0000_0000, 40, -1, 16'd0, 1'b1, 32'h0, 32'h0,         32'h0000_0080};
        vecs[2] = '{2'd2, 2'd0, 32'h0000_0000,  8,  5, 16'd1, 1'b0, 32'h5, 32'hDEAD_BEEF, 32'h0000_0007};
        vecs[3] = '{2'd0, 2'd0, 32'hFFFF_FFFE,  4, -1, 16'd0, 1'b1, 32'h0, 32'h0,         32'h0000_0001};
        vecs[4] = '{2'd0, 2'd2, 32'h0000_0040,  3, -1, 16'd0, 1'b1, 32'h0, 32'h0,         32'h4EA3_49DA};
        vecs[5] = '{2'd1, 2'd1, 32'h0000_0010,  2, -1, 16'd0, 1'b1, 32'h0, 32'h0,         32'hFFFF_FFEE};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_req", {mem_we_o, mem_rd_o}, 2'b00);
        check("rst_status", {err_count, loop_count, first_err_addr, first_err_data}, 96'h0);
        rst = 1'b0;

        // Directed table.
        for (int k = 0; k < 6; k++) begin
            if (vecs[k].mode == 2'd2)
                for (int i = 0; i < vecs[k].count; i++) begin
                    a = vecs[k].base + 32'(i);
                    mem[a] = (i == vecs[k].corrupt) ? 32'hDEAD_BEEF : model_pat(i, a, vecs[k].pat);
                end
            launch(vecs[k].mode, vecs[k].pat, vecs[k].base, vecs[k].count);
            wait_done(60 * vecs[k].count + 100);
            check_run(vecs[k].mode, vecs[k].pat, vecs[k].base, vecs[k].count);
            check($sformatf("vec%0d_err", k), err_count, vecs[k].exp_err);
            check($sformatf("vec%0d_pass", k), pass, vecs[k].exp_pass);
            check($sformatf("vec%0d_ferr", k), {first_err_addr, first_err_data}, {vecs[k].exp_faddr, vecs[k].exp_fdata});
            check($sformatf("vec%0d_last", k), last_rd_data, vecs[k].exp_last);
            if (k == 1) begin
                found = 1'b0;
                foreach (log_q[i])
                    if (!log_q[i].we && log_q[i].addr == 32'd33) begin
                        found = 1'b1;
                        check("sweep_word33", log_q[i].data, 32'h2);
                    end
                check("sweep_word33_read", found, 1'b1);
            end
            if (k == 3 && log_q.size() >= 8) check("wrap_addr", log_q[4].addr, 32'h0);
        end

        // start during busy is ignored; latched parameters stay in force.
        launch(2'd0, 2'd1, 32'h0000_0300, 3);
        repeat (4) @(negedge clk);
        mode = 2'd2; base_addr = 32'h0; word_count = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        check_run(2'd0, 2'd1, 32'h0000_0300, 3);

        // Loop mode, stop during the first read of pass 2.
        launch(2'd3, 2'd0, 32'h0000_0200, 3);
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (loop_count == 16'd1 && mem_rd_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("loop_reach_pass2_read", ok, 1'b1);
        stop = 1'b1;
        wait_done(100);
        stop = 1'b0;
        check("loop_count", loop_count, 16'd1);
        check("loop_txn_count", log_q.size(), 8);
        if (log_q.size() == 8) check("loop_last_txn", {log_q[7].we, log_q[7].addr}, {1'b0, 32'h0000_0200});
        check("loop_req_low", {mem_we_o, mem_rd_o}, 2'b00);
        check("loop_pass", pass, 1'b1);

        // Zero words: immediate done, no request; a start coinciding with done is dropped.
        launch(2'd0, 2'd0, 32'h0000_0500, 0);
        check("zero_done", done, 1'b1);
        check("zero_pass", pass, 1'b1);
        word_count = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_at_done_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        check("start_at_done_still_idle", busy, 1'b0);
        check("zero_no_txn", log_q.size(), 0);

        // Randomized runs against the reference model.
        for (int r = 0; r < 16; r++) begin
            m = 2'($urandom_range(0, 2));
            p = 2'($urandom_range(0, 3));
            b = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
            n = $urandom_range(1, 10);
            if (m == 2'd2)
                for (int i = 0; i < n; i++) begin
                    a = b + 32'(i);
                    v = model_pat(i, a, p);
                    if ($urandom_range(0, 3) == 0) v = v ^ ($urandom | 32'h1);
                    mem[a] = v;
                end
            launch(m, p, b, n);
            wait_done(40 * n + 100);
            check_run(m, p, b, n);
        end

        // Reset while a write waits for ack.
        fixed_lat = 5;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        launch(2'd0, 2'd2, 32'h0000_0600, 4);
        check("pre_rst_we", {mem_we_o, mem_ack_i}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_req", {mem_we_o, mem_rd_o, busy, done, pass}, 5'b0);
        check("rst_mid_bus", {mem_addr_o, mem_data_o}, 64'h0);
        check("rst_mid_status", {err_count, loop_count, first_err_addr, first_err_data}, 96'h0);
        check("rst_mid_last_rd", last_rd_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        fixed_lat = -1;

        check("protocol", proto_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
